// File: rtl/booth_divider.sv
// -----------------------------------------------------------------------------
// booth_divider
//   Sequential signed divider: a 2N-bit two's-complement dividend divided by an
//   N-bit two's-complement divisor, giving an N-bit quotient truncated toward
//   zero and an N-bit remainder that carries the dividend's sign.
//   Magnitudes are divided with a restoring shift/subtract loop, one bit per
//   cycle, and the signs are applied in a final fix-up cycle.
//
//   Latency (counted from the edge that accepts start):
//     normal result  : done rises N+2 edges later
//     early exit     : done rises 2 edges later (quotient overflow seen by the
//                      upper-half pre-check, or divide-by-zero)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a division (accepted only when idle or done)
//   data_D     in   [2N-1:0] signed dividend
//   data_V     in   [N-1:0]  signed divisor
//   quotient   out  [N-1:0]  signed quotient
//   remainder  out  [N-1:0]  signed remainder
//   ovf        out  quotient not representable in N bits
//   dz         out  divide-by-zero (only with BOOTH_DIV_ZERO_DETECT_EN)
//   done       out  result valid; held until the next accepted start or rst
//
// Configuration
//   BOOTH_DIV_ZERO_DETECT_EN  defined   : divisor 0 exits with dz=1, ovf=0
//                             undefined : dz tied 0; divisor 0 falls through
//                                         the pre-check and reports ovf=1
// -----------------------------------------------------------------------------
module booth_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] data_D,
  input  logic [N-1:0]   data_V,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           dz,
  output logic           done
);

`ifdef BOOTH_DIV_ZERO_DETECT_EN
  localparam bit ZERO_DETECT = 1'b1;
`else
  localparam bit ZERO_DETECT = 1'b0;
`endif

  localparam int CW = $clog2(N + 1);
  // Largest quotient magnitudes that still fit an N-bit signed result.
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_next;

  logic [2*N-1:0] d_reg;
  logic [N-1:0]   v_reg;
  logic [N-1:0]   mag_v;      // divisor magnitude (unsigned; -2^(N-1) fits)
  logic [N-1:0]   part_rem;   // partial remainder, always < mag_v in CALC
  logic [N-1:0]   part_quo;   // low dividend bits shifting out, quotient in
  logic [CW-1:0]  cnt;
  logic           sign_q;
  logic           sign_r;
  logic           dz_q;

  // Combinational views of the captured operands, used in LOAD.
  logic [2*N-1:0] load_mag_d;
  logic [N-1:0]   load_mag_v;
  logic           div_zero;
  logic           pre_ovf;

  assign load_mag_d = d_reg[2*N-1] ? -d_reg : d_reg;
  assign load_mag_v = v_reg[N-1]   ? -v_reg : v_reg;
  assign div_zero   = ZERO_DETECT && (v_reg == '0);
  // A quotient of N bits exists only if the upper half is below the divisor;
  // a zero divisor always trips this check.
  assign pre_ovf    = (load_mag_d[2*N-1:N] >= load_mag_v);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic         fits;
  assign shifted = {part_rem, part_quo[N-1]};
  assign diff    = shifted - {1'b0, mag_v};
  assign fits    = (shifted >= {1'b0, mag_v});

  logic fix_ovf;
  assign fix_ovf = sign_q ? (part_quo > MAX_NEG) : (part_quo > MAX_POS);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets its default before the case so every path assigns
  // it; a missing branch would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = LOAD;
      LOAD:       state_next = (div_zero || pre_ovf) ? DONE : CALC;
      CALC:       if (cnt == CW'(1)) state_next = FIX;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg     <= '0;
      v_reg     <= '0;
      mag_v     <= '0;
      part_rem  <= '0;
      part_quo  <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz_q      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            d_reg <= data_D;
            v_reg <= data_V;
            done  <= 1'b0;
            ovf   <= 1'b0;
            dz_q  <= 1'b0;
          end else if (state == DONE) begin
            // Early exits land here with flags already set; raise done now.
            done <= 1'b1;
          end
        end
        LOAD: begin
          sign_q   <= d_reg[2*N-1] ^ v_reg[N-1];
          sign_r   <= d_reg[2*N-1];
          mag_v    <= load_mag_v;
          part_rem <= load_mag_d[2*N-1:N];
          part_quo <= load_mag_d[N-1:0];
          cnt      <= CW'(N);
          if (div_zero) begin
            dz_q      <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else if (pre_ovf) begin
            ovf       <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end
        end
        CALC: begin
          part_rem <= fits ? diff[N-1:0] : shifted[N-1:0];
          part_quo <= {part_quo[N-2:0], fits};
          cnt      <= cnt - CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (fix_ovf) begin
            ovf       <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            quotient  <= sign_q ? -part_quo : part_quo;
            // Negating a zero magnitude yields zero, so a zero remainder is
            // never encoded with the dividend's sign.
            remainder <= sign_r ? -part_rem : part_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign dz = dz_q & ZERO_DETECT;

endmodule

// File: tb/tb_booth_divider.sv
// -----------------------------------------------------------------------------
// tb_booth_divider
//   Directed bench for booth_divider with N=4: a table of dividend/divisor
//   vectors with hand-computed results and latencies, plus sequences for
//   reset, mid-division abort, ignored start pulses and result hold.
// -----------------------------------------------------------------------------
module tb_booth_divider;

  localparam int N = 4;
  localparam int BUDGET = 20;

`ifdef BOOTH_DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] data_D;
  logic [N-1:0]   data_V;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           ovf;
  logic           dz;
  logic           done;

  booth_divider #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_D    (data_D),
    .data_V    (data_V),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2*N-1:0] d;
    logic [N-1:0]   v;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           o;
    logic           z;
    int             lat;
  } vec_t;

  vec_t vecs[16];

  // Drive a start pulse captured by the next rising edge; return just after it.
  task automatic start_div(input logic [2*N-1:0] d, input logic [N-1:0] v);
    @(negedge clk);
    data_D = d;
    data_V = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    data_D = 8'($urandom);
    data_V = 4'($urandom);
  endtask

  // Count edges after the capture edge until done; optionally pulse start
  // with junk operands during cycle pulse_at. lat = -1 if the budget expires.
  task automatic wait_done(input int pulse_at, output int lat);
    lat = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (k == pulse_at) begin
        data_D = 8'd100;
        data_V = 4'd3;
        start  = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    logic [N-1:0] hq, hr;

    //          D       V      q      r      ovf   dz    lat
    vecs[0]  = '{8'd27,  4'd5,  4'h5,  4'h2,  1'b0, 1'b0, 6};
    vecs[1]  = '{8'hE5,  4'd5,  4'hB,  4'hE,  1'b0, 1'b0, 6};
    vecs[2]  = '{8'hE0,  4'd4,  4'h8,  4'h0,  1'b0, 1'b0, 6};
    vecs[3]  = '{8'd32,  4'd4,  4'h0,  4'h0,  1'b1, 1'b0, 6};
    vecs[4]  = '{8'd100, 4'd3,  4'h0,  4'h0,  1'b1, 1'b0, 2};
    vecs[5]  = '{8'd10,  4'd0,  4'h0,  4'h0,  !ZD,  ZD,   2};
    vecs[6]  = '{8'hF9,  4'd2,  4'hD,  4'hF,  1'b0, 1'b0, 6};
    vecs[7]  = '{8'd7,   4'hE,  4'hD,  4'h1,  1'b0, 1'b0, 6};
    vecs[8]  = '{8'hF8,  4'hD,  4'h2,  4'hE,  1'b0, 1'b0, 6};
    vecs[9]  = '{8'hFA,  4'd3,  4'hE,  4'h0,  1'b0, 1'b0, 6};
    vecs[10] = '{8'd0,   4'd5,  4'h0,  4'h0,  1'b0, 1'b0, 6};
    vecs[11] = '{8'd56,  4'h8,  4'h9,  4'h0,  1'b0, 1'b0, 6};
    vecs[12] = '{8'd63,  4'h8,  4'h9,  4'h7,  1'b0, 1'b0, 6};
    vecs[13] = '{8'h80,  4'h8,  4'h0,  4'h0,  1'b1, 1'b0, 2};
    vecs[14] = '{8'd47,  4'd6,  4'h7,  4'h5,  1'b0, 1'b0, 6};
    vecs[15] = '{8'd48,  4'd6,  4'h0,  4'h0,  1'b1, 1'b0, 6};

    rst = 1'b1; start = 1'b0; data_D = '0; data_V = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset done",      32'(done),      32'd0);
    check("reset quotient",  32'(quotient),  32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset ovf",       32'(ovf),       32'd0);
    check("reset dz",        32'(dz),        32'd0);
    rst = 1'b0;

    // Table: each new start is accepted from DONE, back to back.
    for (int i = 0; i < 16; i++) begin
      start_div(vecs[i].d, vecs[i].v);
      check($sformatf("v%0d done cleared", i), 32'(done), 32'd0);
      wait_done(0, lat);
      check($sformatf("v%0d latency", i),   32'(lat),       32'(vecs[i].lat));
      check($sformatf("v%0d quotient", i),  32'(quotient),  32'(vecs[i].q));
      check($sformatf("v%0d remainder", i), 32'(remainder), 32'(vecs[i].r));
      check($sformatf("v%0d ovf", i),       32'(ovf),       32'(vecs[i].o));
      check($sformatf("v%0d dz", i),        32'(dz),        32'(vecs[i].z));
    end

    // Result holds while idle in DONE with changing inputs.
    hq = vecs[15].q; hr = vecs[15].r;
    start_div(8'd27, 4'd5);
    wait_done(0, lat);
    hq = 4'h5; hr = 4'h2;
    repeat (5) begin
      @(negedge clk);
      data_D = 8'($urandom);
      data_V = 4'($urandom);
    end
    #1;
    check("hold done",      32'(done),      32'd1);
    check("hold quotient",  32'(quotient),  32'(hq));
    check("hold remainder", 32'(remainder), 32'(hr));

    // Start pulsed mid-CALC is ignored: same result and latency.
    start_div(8'hE5, 4'd5);
    wait_done(3, lat);
    check("ignored start latency",   32'(lat),       32'd6);
    check("ignored start quotient",  32'(quotient),  32'hB);
    check("ignored start remainder", 32'(remainder), 32'hE);
    check("ignored start ovf",       32'(ovf),       32'd0);

    // Reset during CALC aborts with everything cleared and no result later.
    start_div(8'd27, 4'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort done",      32'(done),      32'd0);
    check("abort quotient",  32'(quotient),  32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort ovf",       32'(ovf),       32'd0);
    check("abort dz",        32'(dz),        32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort stays idle", 32'(done), 32'd0);

    // Divider still works after the abort.
    start_div(8'd27, 4'd5);
    wait_done(0, lat);
    check("post-abort latency",  32'(lat),      32'd6);
    check("post-abort quotient", 32'(quotient), 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
